cfi_csr_sequencer: RTL and testbench

Sequencer and arbiter in front of the single-entry CSR buffer in the execute stage. Shares the buffer between two requesters, regular Zicsr operations from issue and CFI landing-pad label operations (LPSLL/LPSML/LPSUL/LPCLL), and enforces one outstanding CSR operation until commit. Also owns the expected-landing-pad (ELP) state machine, which flags a CFI violation when an indirect jump is not followed by a landing-pad check.

---
 rtl/cfi_csr_sequencer.sv | 132 +++++++++++++
 tb/tb_cfi_csr_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_csr_sequencer.sv
// Arbitrates Zicsr and CFI landing-pad ops into the single-entry CSR buffer, one op in flight until commit; grant is
// combinational in IDLE, op is presented registered the next cycle and held until buf_ready_i; also tracks ELP state.
module cfi_csr_sequencer #(
    parameter int          XLEN          = 64,
    parameter logic [11:0] CSR_LPLR_ADDR = 12'h800,
    parameter logic [11:0] CSR_ELP_ADDR  = 12'h801
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            csr_valid_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            csr_ready_o,
    input  logic            lp_valid_i,
    input  logic [1:0]      lp_op_i,
    input  logic [XLEN-1:0] lp_label_i,
    output logic            lp_ready_o,
    output logic            buf_valid_o,
    output logic [11:0]     buf_addr_o,
    output logic [XLEN-1:0] buf_wdata_o,
    input  logic            buf_ready_i,
    input  logic            commit_i,
    input  logic            ijump_commit_i,
    input  logic            instr_commit_i,
    output logic            elp_o,
    output logic            cfi_violation_o
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ISSUE       = 2'd1;
    localparam logic [1:0] WAIT_COMMIT = 2'd2;

    localparam logic NO_LP       = 1'b0;
    localparam logic LP_EXPECTED = 1'b1;

    logic [1:0]      state_q;
    logic            last_lp_q;
    logic            lpcll_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            elp_q;
    logic            violation_q;

    logic            grant_csr;
    logic            grant_lp;
    logic            take;
    logic [11:0]     csr_addr_mapped;
    logic [11:0]     lp_addr;
    logic            lpcll_commit;
    logic            violation_d;
    logic            elp_d;

    // Round-robin: on a tie the requester not granted last time wins.
    assign grant_csr = csr_valid_i && (!lp_valid_i || last_lp_q);
    assign grant_lp  = lp_valid_i && (!csr_valid_i || !last_lp_q);
    assign take      = (state_q == IDLE) && !flush_i;

    assign csr_ready_o = take && grant_csr;
    assign lp_ready_o  = take && grant_lp;

    assign csr_addr_mapped = (elp_q && (csr_addr_i == CSR_LPLR_ADDR)) ? CSR_ELP_ADDR : csr_addr_i;
    assign lp_addr         = (lp_op_i == 2'd3) ? CSR_ELP_ADDR : CSR_LPLR_ADDR;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            last_lp_q <= 1'b1;
            lpcll_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            lpcll_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_csr) begin
                        state_q   <= ISSUE;
                        last_lp_q <= 1'b0;
                        lpcll_q   <= 1'b0;
                        addr_q    <= csr_addr_mapped;
                        wdata_q   <= csr_wdata_i;
                    end else if (grant_lp) begin
                        state_q   <= ISSUE;
                        last_lp_q <= 1'b1;
                        lpcll_q   <= (lp_op_i == 2'd3);
                        addr_q    <= lp_addr;
                        wdata_q   <= lp_label_i;
                    end
                end
                ISSUE: begin
                    if (buf_ready_i) state_q <= WAIT_COMMIT;
                end
                WAIT_COMMIT: begin
                    if (commit_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign buf_valid_o = (state_q == ISSUE);
    assign buf_addr_o  = addr_q;
    assign buf_wdata_o = wdata_q;

    // The ELP machine watches commits independently of pipeline flushes.
    assign lpcll_commit = (state_q == WAIT_COMMIT) && commit_i && lpcll_q;
    assign violation_d  = (elp_q == LP_EXPECTED) && instr_commit_i && !lpcll_commit;

    always_comb begin
        elp_d = elp_q;
        if (elp_q == LP_EXPECTED && (lpcll_commit || instr_commit_i)) elp_d = NO_LP;
        if (ijump_commit_i) elp_d = LP_EXPECTED;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elp_q       <= NO_LP;
            violation_q <= 1'b0;
        end else begin
            elp_q       <= elp_d;
            violation_q <= violation_d;
        end
    end

    assign elp_o           = elp_q;
    assign cfi_violation_o = violation_q;

endmodule

// File: tb/tb_cfi_csr_sequencer.sv
// Directed bench for cfi_csr_sequencer: grants, round-robin, ELP tracking, flush and async reset.
module tb_cfi_csr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic        csr_ready;
    logic        lp_valid = 1'b0;
    logic [1:0]  lp_op = '0;
    logic [63:0] lp_label = '0;
    logic        lp_ready;
    logic        buf_valid;
    logic [11:0] buf_addr;
    logic [63:0] buf_wdata;
    logic        buf_ready = 1'b0;
    logic        commit = 1'b0;
    logic        ijump_commit = 1'b0;
    logic        instr_commit = 1'b0;
    logic        elp;
    logic        cfi_violation;

    int n_checks = 0;
    int n_fail   = 0;

    cfi_csr_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .csr_valid_i    (csr_valid),
        .csr_addr_i     (csr_addr),
        .csr_wdata_i    (csr_wdata),
        .csr_ready_o    (csr_ready),
        .lp_valid_i     (lp_valid),
        .lp_op_i        (lp_op),
        .lp_label_i     (lp_label),
        .lp_ready_o     (lp_ready),
        .buf_valid_o    (buf_valid),
        .buf_addr_o     (buf_addr),
        .buf_wdata_o    (buf_wdata),
        .buf_ready_i    (buf_ready),
        .commit_i       (commit),
        .ijump_commit_i (ijump_commit),
        .instr_commit_i (instr_commit),
        .elp_o          (elp),
        .cfi_violation_o(cfi_violation)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: accept into the buffer, then commit; returns in IDLE.
    task automatic finish_op();
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_csr_ready", csr_ready, 0);
        check("rst_lp_ready", lp_ready, 0);
        check("rst_buf_valid", buf_valid, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_buf_wdata", buf_wdata, 0);
        check("rst_elp", elp, 0);
        check("rst_violation", cfi_violation, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Lone csr request, held in ISSUE for three cycles.
        tick();
        csr_valid = 1'b1; csr_addr = 12'h300; csr_wdata = 64'h8;
        #1;
        check("t1_csr_ready", csr_ready, 1);
        check("t1_lp_ready", lp_ready, 0);
        check("t1_buf_valid_n", buf_valid, 0);
        tick();
        csr_valid = 1'b0;
        #1;
        check("t1_buf_valid", buf_valid, 1);
        check("t1_buf_addr", buf_addr, 12'h300);
        check("t1_buf_wdata", buf_wdata, 64'h8);
        tick();
        check("t1_hold2_valid", buf_valid, 1);
        check("t1_hold2_addr", buf_addr, 12'h300);
        tick();
        check("t1_hold3_valid", buf_valid, 1);
        check("t1_hold3_wdata", buf_wdata, 64'h8);
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        lp_valid = 1'b1; lp_op = 2'd0; lp_label = 64'h55;
        #1;
        check("t1_wait_buf_valid", buf_valid, 0);
        check("t1_wait_lp_ready", lp_ready, 0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        #1;
        check("t1_idle_lp_ready", lp_ready, 1);
        tick();
        lp_valid = 1'b0;
        #1;
        check("t1_lp_addr", buf_addr, 12'h800);
        check("t1_lp_wdata", buf_wdata, 64'h55);
        finish_op();

        // Tie twice: last grant was lp, so csr then lp.
        csr_valid = 1'b1; csr_addr = 12'h340; csr_wdata = 64'h11;
        lp_valid = 1'b1; lp_op = 2'd1; lp_label = 64'h22;
        #1;
        check("t2_r1_csr_ready", csr_ready, 1);
        check("t2_r1_lp_ready", lp_ready, 0);
        tick();
        check("t2_r1_addr", buf_addr, 12'h340);
        check("t2_r1_wdata", buf_wdata, 64'h11);
        check("t2_issue_lp_ready", lp_ready, 0);
        finish_op();
        check("t2_r2_lp_ready", lp_ready, 1);
        check("t2_r2_csr_ready", csr_ready, 0);
        tick();
        csr_valid = 1'b0; lp_valid = 1'b0;
        #1;
        check("t2_r2_addr", buf_addr, 12'h800);
        check("t2_r2_wdata", buf_wdata, 64'h22);
        finish_op();

        // ELP armed, csr LPLR access remapped, then LPCLL clears it.
        ijump_commit = 1'b1;
        tick();
        ijump_commit = 1'b0;
        #1;
        check("t3_elp_set", elp, 1);
        csr_valid = 1'b1; csr_addr = 12'h800; csr_wdata = 64'h3;
        tick();
        csr_valid = 1'b0;
        #1;
        check("t3_remap_addr", buf_addr, 12'h801);
        finish_op();
        check("t3_elp_kept", elp, 1);
        lp_valid = 1'b1; lp_op = 2'd3; lp_label = 64'h7;
        #1;
        check("t3_lpcll_ready", lp_ready, 1);
        tick();
        lp_valid = 1'b0;
        #1;
        check("t3_lpcll_addr", buf_addr, 12'h801);
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        commit = 1'b1; instr_commit = 1'b1;
        tick();
        commit = 1'b0; instr_commit = 1'b0;
        #1;
        check("t3_elp_clear", elp, 0);
        check("t3_no_violation", cfi_violation, 0);
        tick();
        check("t3_no_violation2", cfi_violation, 0);

        // Missing landing pad.
        ijump_commit = 1'b1;
        tick();
        ijump_commit = 1'b0;
        #1;
        check("t4_elp_set", elp, 1);
        check("t4_viol_pre", cfi_violation, 0);
        instr_commit = 1'b1;
        tick();
        instr_commit = 1'b0;
        #1;
        check("t4_violation", cfi_violation, 1);
        check("t4_elp_clear", elp, 0);
        tick();
        check("t4_violation_end", cfi_violation, 0);

        // Flush in ISSUE and in WAIT_COMMIT.
        csr_valid = 1'b1; csr_addr = 12'h305; csr_wdata = 64'h1;
        tick();
        csr_valid = 1'b0;
        #1;
        check("t5_issue_valid", buf_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("t5_flush1_valid", buf_valid, 0);
        csr_valid = 1'b1; csr_addr = 12'h306; csr_wdata = 64'h2;
        #1;
        check("t5_flush1_regrant", csr_ready, 1);
        tick();
        csr_valid = 1'b0;
        #1;
        check("t5_new_addr", buf_addr, 12'h306);
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("t5_flush2_valid", buf_valid, 0);
        lp_valid = 1'b1; lp_op = 2'd2; lp_label = 64'h9;
        #1;
        check("t5_flush2_regrant", lp_ready, 1);
        tick();
        lp_valid = 1'b0;
        #1;
        check("t5_lpsul_addr", buf_addr, 12'h800);
        finish_op();

        // Async reset in WAIT_COMMIT with ELP set, after a csr grant.
        ijump_commit = 1'b1;
        tick();
        ijump_commit = 1'b0;
        csr_valid = 1'b1; csr_addr = 12'h310; csr_wdata = 64'hA;
        tick();
        csr_valid = 1'b0;
        buf_ready = 1'b1;
        tick();
        buf_ready = 1'b0;
        #1;
        check("t6_pre_elp", elp, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_elp", elp, 0);
        check("t6_rst_buf_valid", buf_valid, 0);
        check("t6_rst_addr", buf_addr, 0);
        check("t6_rst_wdata", buf_wdata, 0);
        check("t6_rst_csr_ready", csr_ready, 0);
        check("t6_rst_lp_ready", lp_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        csr_valid = 1'b1; csr_addr = 12'h320; csr_wdata = 64'hB;
        lp_valid = 1'b1; lp_op = 2'd0; lp_label = 64'hC;
        #1;
        check("t6_tie_csr_ready", csr_ready, 1);
        check("t6_tie_lp_ready", lp_ready, 0);
        tick();
        csr_valid = 1'b0; lp_valid = 1'b0;
        #1;
        check("t6_tie_addr", buf_addr, 12'h320);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
